// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative multi-bit divider.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

    // Per-operation context latched at the accepting edge.
    typedef struct packed {
        logic rem_sel;
        logic q_neg;
        logic r_neg;
    } div_ctx_t;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step retiring BITS_PER_CYCLE quotient bits, MSB first.
module div_iter_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0]           rem,
    input  logic [XLEN-1:0]           shreg,
    input  logic [XLEN-1:0]           div_mag,
    output logic [XLEN-1:0]           rem_next,
    output logic [XLEN-1:0]           shreg_next,
    output logic [BITS_PER_CYCLE-1:0] qbits
);

    logic [XLEN:0]   r_acc;
    logic [XLEN-1:0] s_acc;
    logic            ge;

    // The partial remainder stays below the divisor, so one extra bit covers the shift.
    always_comb begin
        r_acc = {1'b0, rem};
        s_acc = shreg;
        qbits = '0;
        ge    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_acc = {r_acc[XLEN-1:0], s_acc[XLEN-1]};
            s_acc = s_acc << 1;
            ge    = (r_acc >= {1'b0, div_mag});
            if (ge) begin
                r_acc = r_acc - {1'b0, div_mag};
            end
            qbits = (qbits << 1) | BITS_PER_CYCLE'(ge);
        end
        rem_next   = r_acc[XLEN-1:0];
        shreg_next = s_acc;
    end

endmodule

// File: rtl/div_unit_multibit.sv
// RV32M/RV64M divide/remainder unit: special cases resolve at accept, others iterate.
module div_unit_multibit
    import div_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            data_valid,
    input  logic [1:0]      operation,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic [XLEN-1:0] product_o,
    output logic            data_ready
);

    localparam int unsigned NUM_ITER = XLEN / BITS_PER_CYCLE;
    localparam int unsigned ITER_W   = $clog2(NUM_ITER) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [ITER_W-1:0] count_q, count_d;
    div_ctx_t          ctx_q, ctx_d;
    logic [XLEN-1:0]   dvs_mag_q, dvs_mag_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   shreg_q, shreg_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   product_d;
    logic              busy_d, data_ready_d;

    logic              in_signed, in_rem, dvd_neg, dvs_neg;
    logic              div_zero, overflow, early_out, special;
    logic [XLEN-1:0]   dvd_mag, dvs_mag, special_res;

    logic [XLEN-1:0]           step_rem, step_sh;
    logic [BITS_PER_CYCLE-1:0] step_q;
    logic [XLEN-1:0]           quot_next, q_fix, r_fix, fix_res;

    // Decode the incoming request: magnitudes and the cases that need no iteration.
    always_comb begin
        in_signed = is_signed_op(operation);
        in_rem    = is_rem_op(operation);
        dvd_neg   = in_signed & dividend[XLEN-1];
        dvs_neg   = in_signed & divisor[XLEN-1];
        dvd_mag   = dvd_neg ? (XLEN'(0) - dividend) : dividend;
        dvs_mag   = dvs_neg ? (XLEN'(0) - divisor) : divisor;
        div_zero  = (divisor == '0);
        overflow  = in_signed && (dividend == INT_MIN) && (divisor == '1);
        early_out = (dvd_mag < dvs_mag);
        special   = div_zero | overflow | early_out;
        if (div_zero) begin
            special_res = in_rem ? dividend : '1;
        end else if (overflow) begin
            special_res = in_rem ? '0 : dividend;
        end else begin
            special_res = in_rem ? dividend : '0;
        end
    end

    div_iter_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem        (rem_q),
        .shreg      (shreg_q),
        .div_mag    (dvs_mag_q),
        .rem_next   (step_rem),
        .shreg_next (step_sh),
        .qbits      (step_q)
    );

    // The final step runs in FIX and feeds the sign correction directly.
    always_comb begin
        quot_next = (quot_q << BITS_PER_CYCLE) | XLEN'(step_q);
        q_fix     = ctx_q.q_neg ? (XLEN'(0) - quot_next) : quot_next;
        r_fix     = ctx_q.r_neg ? (XLEN'(0) - step_rem) : step_rem;
        fix_res   = ctx_q.rem_sel ? r_fix : q_fix;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ctx_d        = ctx_q;
        dvs_mag_d    = dvs_mag_q;
        rem_d        = rem_q;
        shreg_d      = shreg_q;
        quot_d       = quot_q;
        product_d    = product_o;
        busy_d       = busy;
        data_ready_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (data_valid) begin
                    ctx_d.rem_sel = in_rem;
                    ctx_d.q_neg   = dvd_neg ^ dvs_neg;
                    ctx_d.r_neg   = dvd_neg;
                    dvs_mag_d     = dvs_mag;
                    rem_d         = '0;
                    shreg_d       = dvd_mag;
                    quot_d        = '0;
                    count_d       = ITER_W'(NUM_ITER);
                    if (special) begin
                        state_d      = S_DONE;
                        data_ready_d = 1'b1;
                        product_d    = special_res;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                rem_d   = step_rem;
                shreg_d = step_sh;
                quot_d  = quot_next;
                count_d = count_q - ITER_W'(1);
                if (count_q == ITER_W'(2)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                count_d      = count_q - ITER_W'(1);
                state_d      = S_DONE;
                busy_d       = 1'b0;
                data_ready_d = 1'b1;
                product_d    = fix_res;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A pipeline kill drops everything in flight, including a same-cycle request.
        if (flush) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            data_ready_d = 1'b0;
            product_d    = product_o;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            ctx_q      <= '0;
            dvs_mag_q  <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
            quot_q     <= '0;
            product_o  <= '0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ctx_q      <= ctx_d;
            dvs_mag_q  <= dvs_mag_d;
            rem_q      <= rem_d;
            shreg_q    <= shreg_d;
            quot_q     <= quot_d;
            product_o  <= product_d;
            busy       <= busy_d;
            data_ready <= data_ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit_multibit.sv
// Bench for div_unit_multibit: radix-2 and radix-16 instances against a latency/arithmetic model.
module tb_div_unit_multibit;
    import div_pkg::*;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        dv1, dv4;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        busy1, rdy1, busy4, rdy4;
    logic [31:0] prod1, prod4;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    div_unit_multibit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .CLK(CLK), .rst_n(rst_n), .flush(flush), .data_valid(dv1), .operation(op),
        .dividend(opa), .divisor(opb), .busy(busy1), .product_o(prod1), .data_ready(rdy1)
    );

    div_unit_multibit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .CLK(CLK), .rst_n(rst_n), .flush(flush), .data_valid(dv4), .operation(op),
        .dividend(opa), .divisor(opb), .busy(busy4), .product_o(prod4), .data_ready(rdy4)
    );

    // Architectural result and whether it needs no iteration.
    function automatic void ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit special);
        bit     sgn;
        bit     rem;
        longint sa, sb, ma, mb;
        sgn = (o == OP_DIV) || (o == OP_REM);
        rem = (o == OP_REM) || (o == OP_REMU);
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            special = 1'b1;
            res     = rem ? a : 32'hFFFF_FFFF;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            special = 1'b1;
            res     = rem ? 32'd0 : a;
        end else begin
            special = (ma < mb);
            res     = rem ? 32'(sa % sb) : 32'(sa / sb);
        end
    endfunction

    bit          m_busy[2];
    bit          m_ready[2];
    int          m_left[2];
    logic [31:0] m_pend[2];
    logic [31:0] m_prod[2];

    // Model: a request completes N+1 edges after acceptance (N = 32 or 8), or 1 edge if special.
    always @(posedge CLK or negedge rst_n) begin
        logic [31:0] res;
        bit          sp;
        bit          req;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i]  = 1'b0;
                m_ready[i] = 1'b0;
                m_left[i]  = 0;
                m_pend[i]  = '0;
                m_prod[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                req        = (i == 0) ? dv1 : dv4;
                m_ready[i] = 1'b0;
                if (flush) begin
                    m_busy[i] = 1'b0;
                end else if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_busy[i]  = 1'b0;
                        m_ready[i] = 1'b1;
                        m_prod[i]  = m_pend[i];
                    end
                end else if (req) begin
                    ref_div(op, opa, opb, res, sp);
                    if (sp) begin
                        m_ready[i] = 1'b1;
                        m_prod[i]  = res;
                    end else begin
                        m_busy[i] = 1'b1;
                        m_left[i] = (i == 0) ? 32 : 8;
                        m_pend[i] = res;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("busy1", 32'(busy1), 32'(m_busy[0]));
        chk("ready1", 32'(rdy1), 32'(m_ready[0]));
        chk("prod1", prod1, m_prod[0]);
        chk("busy4", 32'(busy4), 32'(m_busy[1]));
        chk("ready4", 32'(rdy4), 32'(m_ready[1]));
        chk("prod4", prod4, m_prod[1]);
    end

    // Issue one request at a negedge; return at the negedge where data_ready is seen or the flush landed.
    task automatic run_op(input int which, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int poke_at,
                          output logic [31:0] got, output int edges, output bit ok);
        op    = o;
        opa   = a;
        opb   = b;
        dv1   = (which == 0);
        dv4   = (which != 0);
        flush = (flush_at == 1);
        ok    = 1'b0;
        got   = '0;
        @(posedge CLK);
        @(negedge CLK);
        edges = 1;
        for (int g = 0; g < 200; g++) begin
            dv1   = 1'b0;
            dv4   = 1'b0;
            flush = 1'b0;
            if ((which == 0) ? rdy1 : rdy4) begin
                ok  = 1'b1;
                got = (which == 0) ? prod1 : prod4;
                break;
            end
            if (flush_at > 0 && edges >= flush_at) break;
            if (edges >= 100) break;
            flush = (edges + 1 == flush_at);
            if (edges == poke_at) begin
                op  = OP_DIVU;
                opa = $urandom;
                opb = $urandom_range(1, 1000);
                dv1 = (which == 0);
                dv4 = (which != 0);
            end
            @(posedge CLK);
            @(negedge CLK);
            edges++;
        end
    endtask

    task automatic lit(input string name, input int which, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_edges, input int poke_at);
        logic [31:0] got;
        int          edges;
        bit          ok;
        run_op(which, o, a, b, 0, poke_at, got, edges, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: no data_ready within bound, got %0d want 1", name, ok);
        end else begin
            chk({name, "_val"}, got, exp);
            chk({name, "_lat"}, 32'(edges), 32'(exp_edges));
        end
    endtask

    initial begin
        logic [31:0] got, a, b;
        logic [1:0]  o;
        int          edges, w, cls, fa;
        bit          ok;

        rst_n = 1'b0;
        flush = 1'b0;
        dv1   = 1'b0;
        dv4   = 1'b0;
        op    = OP_DIV;
        opa   = '0;
        opb   = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_prod", prod1, 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        lit("div_m7_3", 0, OP_DIV, -32'sd7, 32'd3, 32'hFFFF_FFFE, 33, 0);
        lit("rem_149_m2", 0, OP_REM, 32'd149, -32'sd2, 32'd1, 33, 0);
        lit("rem_m149_m5", 0, OP_REM, -32'sd149, -32'sd5, 32'hFFFF_FFFC, 33, 0);
        lit("divu_25_3", 0, OP_DIVU, 32'd25, 32'd3, 32'd8, 33, 0);
        lit("remu_25_3", 0, OP_REMU, 32'd25, 32'd3, 32'd1, 33, 0);
        lit("div_5_0", 0, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        lit("rem_5_0", 0, OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        lit("div_ovf", 0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        lit("rem_ovf", 0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        lit("div_early", 0, OP_DIV, -32'sd5, 32'd32, 32'd0, 1, 0);
        lit("rem_early", 0, OP_REM, -32'sd5, 32'd32, 32'hFFFF_FFFB, 1, 0);
        lit("div4_1000_7", 1, OP_DIV, 32'd1000, 32'd7, 32'd142, 9, 0);

        // Flush at edge 10 of a long run: no result, product held.
        run_op(0, OP_DIVU, 32'hFFFF_FFFF, 32'd3, 10, 0, got, edges, ok);
        chk("flush_noready", 32'(ok), 32'd0);
        chk("flush_busy", 32'(busy1), 32'd0);
        repeat (40) @(negedge CLK);
        chk("flush_hold", prod1, 32'hFFFF_FFFB);
        lit("divu_9_3", 0, OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

        // A request while busy is ignored.
        lit("ignore_busy", 0, OP_DIV, -32'sd7, 32'd3, 32'hFFFF_FFFE, 33, 5);

        // Reset mid-iteration clears outputs immediately.
        op  = OP_DIVU;
        opa = 32'd100;
        opb = 32'd7;
        dv1 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        dv1 = 1'b0;
        repeat (4) @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy1), 32'd0);
        chk("rstmid_ready", 32'(rdy1), 32'd0);
        chk("rstmid_prod", prod1, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        lit("after_rst", 0, OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

        for (int n = 0; n < 80; n++) begin
            w   = $urandom_range(0, 1);
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            cls = $urandom_range(0, 5);
            case (cls)
                1: b = $urandom_range(1, 20);
                2: b = 32'd0;
                3: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                4: a = $urandom_range(0, 50);
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            fa = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0;
            run_op(w, o, a, b, fa, 0, got, edges, ok);
            if (fa == 0) begin
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL rand_timeout: op %0d a %h b %h got ready %0d want 1", o, a, b, ok);
                end
            end
        end

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
